// File: rtl/ascon_pack.sv
// rtl/ascon_pack.sv - Shared ASCON state type, FSM enum, round constants and S-box
package ascon_pack;

  // Word 0 is the S-box MSB lane, word 4 the LSB lane
  typedef logic [4:0][63:0] type_state;

  typedef enum logic [1:0] {IDLE, RUN, DONE} type_perm_fsm;

  // Round constant for absolute round index 0..11; out-of-range indices add nothing
  function automatic logic [7:0] round_constant(input logic [3:0] r);
    logic [7:0] c;
    c = 8'h00;
    case (r)
      4'd0:  c = 8'hF0;
      4'd1:  c = 8'hE1;
      4'd2:  c = 8'hD2;
      4'd3:  c = 8'hC3;
      4'd4:  c = 8'hB4;
      4'd5:  c = 8'hA5;
      4'd6:  c = 8'h96;
      4'd7:  c = 8'h87;
      4'd8:  c = 8'h78;
      4'd9:  c = 8'h69;
      4'd10: c = 8'h5A;
      4'd11: c = 8'h4B;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // ASCON 5-bit S-box, 32 entries
  function automatic logic [4:0] sbox(input logic [4:0] x);
    logic [4:0] y;
    y = 5'h00;
    case (x)
      5'h00: y = 5'h04; 5'h01: y = 5'h0B; 5'h02: y = 5'h1F; 5'h03: y = 5'h14;
      5'h04: y = 5'h1A; 5'h05: y = 5'h15; 5'h06: y = 5'h09; 5'h07: y = 5'h02;
      5'h08: y = 5'h1B; 5'h09: y = 5'h05; 5'h0A: y = 5'h08; 5'h0B: y = 5'h12;
      5'h0C: y = 5'h1D; 5'h0D: y = 5'h03; 5'h0E: y = 5'h06; 5'h0F: y = 5'h1C;
      5'h10: y = 5'h1E; 5'h11: y = 5'h13; 5'h12: y = 5'h07; 5'h13: y = 5'h0E;
      5'h14: y = 5'h00; 5'h15: y = 5'h0D; 5'h16: y = 5'h11; 5'h17: y = 5'h18;
      5'h18: y = 5'h10; 5'h19: y = 5'h0C; 5'h1A: y = 5'h01; 5'h1B: y = 5'h19;
      5'h1C: y = 5'h16; 5'h1D: y = 5'h0A; 5'h1E: y = 5'h0F; 5'h1F: y = 5'h17;
      default: y = 5'h00;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/pc.sv
// rtl/pc.sv - Constant addition layer of one ASCON round
module pc
  import ascon_pack::*;
(
  input  type_state  x,
  input  logic [3:0] round,
  output type_state  y
);

  // Only the low byte of word 2 receives the round constant
  always_comb begin
    y = x;
    y[2][7:0] = x[2][7:0] ^ round_constant(round);
  end

endmodule

// File: rtl/pl.sv
// rtl/pl.sv - Linear diffusion layer, per-word xor of two right rotations
module pl
  import ascon_pack::*;
(
  input  type_state x,
  output type_state y
);

  assign y[0] = x[0] ^ {x[0][18:0], x[0][63:19]} ^ {x[0][27:0], x[0][63:28]};
  assign y[1] = x[1] ^ {x[1][60:0], x[1][63:61]} ^ {x[1][38:0], x[1][63:39]};
  assign y[2] = x[2] ^ {x[2][0],    x[2][63:1]}  ^ {x[2][5:0],  x[2][63:6]};
  assign y[3] = x[3] ^ {x[3][9:0],  x[3][63:10]} ^ {x[3][16:0], x[3][63:17]};
  assign y[4] = x[4] ^ {x[4][6:0],  x[4][63:7]}  ^ {x[4][40:0], x[4][63:41]};

endmodule

// File: rtl/ps.sv
// rtl/ps.sv - Bit-sliced S-box substitution layer across the 64 state columns
module ps
  import ascon_pack::*;
(
  input  type_state x,
  output type_state y
);

  logic [4:0] col;
  logic [4:0] sub;

  // Each column gathers one bit per word, word 0 as the MSB of the S-box index
  always_comb begin
    y   = '0;
    col = '0;
    sub = '0;
    for (int i = 0; i < 64; i++) begin
      col = {x[0][i], x[1][i], x[2][i], x[3][i], x[4][i]};
      sub = sbox(col);
      y[0][i] = sub[4];
      y[1][i] = sub[3];
      y[2][i] = sub[2];
      y[3][i] = sub[1];
      y[4][i] = sub[0];
    end
  end

endmodule

// File: rtl/permutation_core.sv
// rtl/permutation_core.sv - Iterative ASCON permutation, one round per clock
module permutation_core
  import ascon_pack::*;
#(
  parameter int NB_ROUNDS_MAX = 12
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic [3:0] rounds_i,
  input  type_state  state_i,
  output logic       busy_o,
  output logic       done_o,
  output type_state  state_o
);

  localparam logic [3:0] ROUNDS_MAX = 4'(NB_ROUNDS_MAX);
  localparam logic [3:0] LAST_ROUND = 4'(NB_ROUNDS_MAX - 1);

  type_perm_fsm fsm_q, fsm_d;
  type_state    state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic [3:0]   rounds_eff;
  logic [3:0]   round_first;
  type_state    pc_out, ps_out, pl_out;

  pc u_pc (.x(state_q), .round(round_q), .y(pc_out));
  ps u_ps (.x(pc_out), .y(ps_out));
  pl u_pl (.x(ps_out), .y(pl_out));

  // Out-of-range round requests fall back to the full p^a length
  assign rounds_eff  = (rounds_i >= 4'd1 && rounds_i <= ROUNDS_MAX) ? rounds_i : ROUNDS_MAX;
  assign round_first = ROUNDS_MAX - rounds_eff;

  // Next-state logic: load on an accepted start, apply one round per cycle in RUN
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    round_d = round_q;
    case (fsm_q)
      IDLE, DONE: begin
        if (start_i) begin
          fsm_d   = RUN;
          state_d = state_i;
          round_d = round_first;
        end else begin
          fsm_d = IDLE;
        end
      end
      RUN: begin
        state_d = pl_out;
        round_d = round_q + 4'd1;
        if (round_q == LAST_ROUND) fsm_d = DONE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  // State register, round counter and FSM state
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      round_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  assign busy_o  = (fsm_q == RUN);
  assign done_o  = (fsm_q == DONE);
  assign state_o = state_q;

endmodule

// File: tb/tb_permutation_core.sv
// tb/tb_permutation_core.sv - Directed self-checking bench for permutation_core
module tb_permutation_core;
  import ascon_pack::*;

  logic       clock_i = 1'b0;
  logic       resetb_i;
  logic       start_i;
  logic [3:0] rounds_i;
  type_state  state_i;
  logic       busy_o;
  logic       done_o;
  type_state  state_o;

  int n_cmp = 0;
  int n_bad = 0;

  permutation_core dut (
    .clock_i  (clock_i),
    .resetb_i (resetb_i),
    .start_i  (start_i),
    .rounds_i (rounds_i),
    .state_i  (state_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .state_o  (state_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic check_st(input string tag, input type_state obs, input type_state exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_w(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs == exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Reference round in the boolean bit-sliced formulation of the ASCON S-box
  function automatic type_state model_round(input type_state s, input int r);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    type_state o;
    x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
    x2 = x2 ^ 64'(((15 - r) << 4) | r);
    x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
    x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
    o[0] = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
    o[1] = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
    o[2] = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
    o[3] = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
    o[4] = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
    return o;
  endfunction

  function automatic type_state model_perm(input type_state s, input int n);
    type_state t;
    t = s;
    for (int r = 12 - n; r < 12; r++) t = model_round(t, r);
    return t;
  endfunction

  function automatic type_state rand_state();
    type_state s;
    for (int w = 0; w < 5; w++) s[w] = {$urandom(), $urandom()};
    return s;
  endfunction

  // Start one run and wait (bounded) for done_o; lat counts edges after the start edge
  task automatic do_run(input logic [3:0] rounds, input type_state st, output type_state res,
                        output int lat, output int busy_cnt, output logic busy_at_done);
    @(negedge clock_i);
    start_i = 1'b1; rounds_i = rounds; state_i = st;
    @(negedge clock_i);
    start_i = 1'b0;
    lat = 0; busy_cnt = 0;
    while (done_o !== 1'b1 && lat < 40) begin
      if (busy_o === 1'b1) busy_cnt++;
      @(negedge clock_i);
      lat++;
    end
    res = state_o;
    busy_at_done = busy_o;
  endtask

  initial begin
    type_state s, res, last;
    int lat, bc, cyc, nd, prev;
    logic bad;

    resetb_i = 1'b0; start_i = 1'b0; rounds_i = 4'd0; state_i = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock_i);
      start_i = 1'($urandom()); rounds_i = 4'($urandom()); state_i = rand_state();
    end
    #1;
    check_bit("rst_busy", busy_o, 1'b0);
    check_bit("rst_done", done_o, 1'b0);
    check_st("rst_state", state_o, '0);
    check_int("rst_fsm", int'(dut.fsm_q), int'(IDLE));
    @(negedge clock_i);
    resetb_i = 1'b1; start_i = 1'b0;

    // Single round from zero state uses c=0x4B
    do_run(4'd1, '0, res, lat, bc, bad);
    check_int("r1_latency", lat, 1);
    check_int("r1_busy_cycles", bc, 1);
    check_bit("r1_busy_at_done", bad, 1'b0);
    check_w("r1_word0", res[0], 64'h000964B00000004B);
    check_w("r1_word4", res[4], 64'h0);
    check_st("r1_model", res, model_perm('0, 1));
    @(negedge clock_i);
    check_bit("r1_done_pulse", done_o, 1'b0);

    // p^a from zero state: inspect state after the first round (c=0xF0)
    @(negedge clock_i);
    start_i = 1'b1; rounds_i = 4'd12; state_i = '0;
    @(negedge clock_i);
    start_i = 1'b0;
    check_bit("pa0_busy_e0", busy_o, 1'b1);
    @(negedge clock_i);
    check_w("pa0_first_word0", state_o[0], 64'h001E0F00000000F0);
    check_w("pa0_first_word4", state_o[4], 64'h0);
    lat = 1;
    while (done_o !== 1'b1 && lat < 40) begin
      @(negedge clock_i);
      lat++;
    end
    check_int("pa0_latency", lat, 12);
    check_st("pa0_model", state_o, model_perm('0, 12));

    // p^a on a random state
    s = rand_state();
    do_run(4'd12, s, res, lat, bc, bad);
    check_int("pa_latency", lat, 12);
    check_int("pa_busy_cycles", bc, 12);
    check_bit("pa_busy_at_done", bad, 1'b0);
    check_st("pa_model", res, model_perm(s, 12));

    // p^b on a random state and on zero state
    s = rand_state();
    do_run(4'd6, s, res, lat, bc, bad);
    check_int("pb_latency", lat, 6);
    check_int("pb_busy_cycles", bc, 6);
    check_st("pb_model", res, model_perm(s, 6));
    do_run(4'd6, '0, res, lat, bc, bad);
    check_st("pb_zero_model", res, model_perm('0, 6));

    // Round-count boundaries: 0 and 13 fall back to 12, 8 is honoured
    s = rand_state();
    do_run(4'd0, s, res, lat, bc, bad);
    check_int("r0_latency", lat, 12);
    check_st("r0_model", res, model_perm(s, 12));
    s = rand_state();
    do_run(4'd13, s, res, lat, bc, bad);
    check_int("r13_latency", lat, 12);
    check_st("r13_model", res, model_perm(s, 12));
    s = rand_state();
    do_run(4'd8, s, res, lat, bc, bad);
    check_int("r8_latency", lat, 8);
    check_st("r8_model", res, model_perm(s, 8));
    last = res;

    // state_o holds in IDLE while inputs change without a start
    @(negedge clock_i);
    state_i = rand_state(); rounds_i = 4'd3;
    repeat (3) @(negedge clock_i);
    check_st("idle_hold", state_o, last);
    check_bit("idle_busy", busy_o, 1'b0);

    // start_i held high: RUN ignores it, every DONE restarts, period 7
    s = rand_state();
    @(negedge clock_i);
    start_i = 1'b1; rounds_i = 4'd6; state_i = s;
    cyc = 0; nd = 0; prev = 0;
    while (nd < 3 && cyc < 60) begin
      @(negedge clock_i);
      cyc++;
      if (done_o === 1'b1) begin
        nd++;
        check_st("b2b_model", state_o, model_perm(s, 6));
        check_bit("b2b_busy_at_done", busy_o, 1'b0);
        if (nd > 1) check_int("b2b_period", cyc - prev, 7);
        prev = cyc;
      end
    end
    start_i = 1'b0;
    check_int("b2b_done_count", nd, 3);
    @(negedge clock_i);
    check_bit("b2b_end_done", done_o, 1'b0);
    check_int("b2b_end_fsm", int'(dut.fsm_q), int'(IDLE));

    // Asynchronous reset after 5 of 12 rounds
    s = rand_state();
    @(negedge clock_i);
    start_i = 1'b1; rounds_i = 4'd12; state_i = s;
    @(negedge clock_i);
    start_i = 1'b0;
    repeat (5) @(negedge clock_i);
    resetb_i = 1'b0;
    #1;
    check_st("arst_state", state_o, '0);
    check_bit("arst_busy", busy_o, 1'b0);
    check_bit("arst_done", done_o, 1'b0);
    check_int("arst_fsm", int'(dut.fsm_q), int'(IDLE));
    repeat (2) @(negedge clock_i);
    resetb_i = 1'b1;
    nd = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock_i);
      if (done_o !== 1'b0) nd++;
    end
    check_int("arst_no_done", nd, 0);
    s = rand_state();
    do_run(4'd12, s, res, lat, bc, bad);
    check_int("arst_rerun_latency", lat, 12);
    check_st("arst_rerun_model", res, model_perm(s, 12));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
